// File: rtl/fortuna_pkg.sv
// Shared types and sizing for the Fortuna reseed controller.
package fortuna_pkg;

  localparam int unsigned KEY_W              = 256;
  localparam int unsigned CNT_W              = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/fortuna_reseed_ctrl.sv
// Fortuna generator reseed: hashes key^seed through an external sha256d core
// and installs the digest as the new key, with a watchdog on the core.
module fortuna_reseed_ctrl
  import fortuna_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [KEY_W-1:0]  KEY_INIT       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_data,
  output logic             sha_init,
  output logic [KEY_W-1:0] sha_clear_input,
  input  logic             sha_ready,
  input  logic [KEY_W-1:0] sha_hash,
  input  logic             sha_hash_valid,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_update,
  output logic [CNT_W-1:0] reseed_cnt,
  output logic             busy,
  output logic             error,
  input  logic             err_clear
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  // The counter trips on the edge where it would reach TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  state_t           state;
  state_t           state_nxt;
  logic [KEY_W-1:0] block;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_busy;
  logic             accept;
  logic             capture;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_busy = (state == ST_PEND) || (state == ST_ISSUE) ||
                   (state == ST_SETTLE) || (state == ST_WAIT);
  assign accept  = req_valid && (state == ST_IDLE);
  assign capture = (state == ST_WAIT) && sha_ready && sha_hash_valid;
  assign timeout = in_busy && (tmo_cnt == TMO_LAST) && !capture;

  assign req_ready       = (state == ST_IDLE);
  assign busy            = in_busy;
  assign sha_init        = (state == ST_ISSUE);
  assign error           = (state == ST_ERROR);
  assign sha_clear_input = block;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept)    state_nxt = ST_PEND;
      ST_PEND:   if (sha_ready) state_nxt = ST_ISSUE;
      ST_ISSUE:                 state_nxt = ST_SETTLE;
      // One dead cycle lets the core drop sha_ready after the init pulse.
      ST_SETTLE:                state_nxt = ST_WAIT;
      ST_WAIT:   if (capture)   state_nxt = ST_IDLE;
      ST_ERROR:  if (err_clear) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
    if (timeout) state_nxt = ST_ERROR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block      <= '0;
      key        <= KEY_INIT;
      key_valid  <= 1'b0;
      key_update <= 1'b0;
      reseed_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      key_update <= capture;
      if (accept) begin
        block   <= key ^ req_data;
        tmo_cnt <= '0;
      end else if (in_busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (capture) begin
        key        <= sha_hash;
        key_valid  <= 1'b1;
        reseed_cnt <= sat_inc(reseed_cnt);
      end
    end
  end

endmodule

// File: tb/tb_fortuna_reseed_ctrl.sv
// Directed bench for fortuna_reseed_ctrl with a behavioural sha256d stub and a
// scoreboard of expected blocks and keys.
module tb_fortuna_reseed_ctrl;
  import fortuna_pkg::*;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [KEY_W-1:0] req_data;
  logic             sha_init;
  logic [KEY_W-1:0] sha_clear_input;
  logic             sha_ready;
  logic [KEY_W-1:0] sha_hash;
  logic             sha_hash_valid;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_update;
  logic [CNT_W-1:0] reseed_cnt;
  logic             busy;
  logic             error;
  logic             err_clear;

  fortuna_reseed_ctrl #(
    .TIMEOUT_CYCLES(16),
    .KEY_INIT      ('0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .sha_init       (sha_init),
    .sha_clear_input(sha_clear_input),
    .sha_ready      (sha_ready),
    .sha_hash       (sha_hash),
    .sha_hash_valid (sha_hash_valid),
    .key            (key),
    .key_valid      (key_valid),
    .key_update     (key_update),
    .reseed_cnt     (reseed_cnt),
    .busy           (busy),
    .error          (error),
    .err_clear      (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // SHA-256 of a single 32-byte message (one padded block).
  function automatic logic [255:0] sha256_32(input logic [255:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 8; i++) w[i] = m[255-32*i -: 32];
    w[8] = 32'h80000000;
    for (int i = 9; i < 15; i++) w[i] = 32'h0;
    w[15] = 32'd256;
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
    e = H0[4]; f = H0[5]; g = H0[6]; hh = H0[7];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {H0[0] + a, H0[1] + b, H0[2] + c, H0[3] + d,
            H0[4] + e, H0[5] + f, H0[6] + g, H0[7] + hh};
  endfunction

  // Behavioural core: after sha_init, waits core_lat cycles then presents the digest.
  int core_lat;
  int core_cnt;
  bit core_active;
  bit core_dead;
  bit hold_off;

  always @(negedge clk) begin
    if (!reset_n) begin
      core_active    = 1'b0;
      sha_ready      = !hold_off;
      sha_hash_valid = 1'b0;
    end else if (sha_init) begin
      core_active    = 1'b1;
      core_cnt       = core_lat;
      sha_ready      = 1'b0;
      sha_hash_valid = 1'b0;
    end else if (core_active) begin
      if (!core_dead) begin
        if (core_cnt == 0) begin
          core_active    = 1'b0;
          sha_ready      = 1'b1;
          sha_hash_valid = 1'b1;
          sha_hash       = sha256_32(sha_clear_input);
        end else begin
          core_cnt--;
        end
      end
    end else begin
      sha_ready = !hold_off;
    end
  end

  int n_cmp;
  int n_err;
  logic [KEY_W-1:0] exp_blk [$];
  logic [KEY_W-1:0] exp_key [$];
  logic [KEY_W-1:0] model_key;
  logic [CNT_W-1:0] model_cnt;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reseed(input string tag, input logic [255:0] seed, input int lat,
                           input int hold, output int latency);
    logic [255:0] blk;
    logic [255:0] cur;
    int inits;
    blk = model_key ^ seed;
    exp_blk.push_back(blk);
    exp_key.push_back(sha256_32(blk));
    core_lat = lat;
    hold_off = (hold > 0);
    check({tag, "_req_ready"}, 256'(req_ready), 256'd1);
    req_valid = 1'b1;
    req_data  = seed;
    tick();
    req_valid = 1'b0;
    req_data  = '0;
    latency = 0;
    inits   = 0;
    if (hold > 0) begin
      repeat (hold) begin
        tick();
        latency++;
        if (sha_init) inits++;
      end
      check({tag, "_hold_state"}, 256'(dut.state), 256'(ST_PEND));
      check({tag, "_hold_inits"}, 256'(inits), 256'd0);
      hold_off = 1'b0;
    end
    while (!key_update && latency < 60) begin
      tick();
      latency++;
      if (sha_init) begin
        inits++;
        if (exp_blk.size() == 0) check({tag, "_blk_queue"}, 256'd0, 256'd1);
        else begin
          cur = exp_blk.pop_front();
          check({tag, "_sha_clear_input"}, sha_clear_input, cur);
        end
      end
    end
    check({tag, "_key_update"}, 256'(key_update), 256'd1);
    if (key_update && exp_key.size() > 0) begin
      model_key = exp_key.pop_front();
      model_cnt = (&model_cnt) ? model_cnt : model_cnt + 1'b1;
      check({tag, "_key"}, key, model_key);
      check({tag, "_reseed_cnt"}, 256'(reseed_cnt), 256'(model_cnt));
      check({tag, "_key_valid"}, 256'(key_valid), 256'd1);
      check({tag, "_init_pulses"}, 256'(inits), 256'd1);
      check({tag, "_blk_stable"}, sha_clear_input, blk);
      tick();
      check({tag, "_update_pulse"}, 256'(key_update), 256'd0);
    end
  endtask

  localparam logic [255:0] SEED = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] KEY1 = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;

  initial begin
    #200000;
    $display("FAIL watchdog simulation_time observed=expired expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int upd;
    n_cmp = 0; n_err = 0;
    core_lat = 0; core_cnt = 0; core_active = 0; core_dead = 0; hold_off = 0;
    sha_ready = 1'b0; sha_hash_valid = 1'b0; sha_hash = '0;
    req_valid = 1'b0; req_data = '0; err_clear = 1'b0;
    model_key = '0; model_cnt = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    // Reset values
    check("rst_key", key, 256'd0);
    check("rst_key_valid", 256'(key_valid), 256'd0);
    check("rst_key_update", 256'(key_update), 256'd0);
    check("rst_reseed_cnt", 256'(reseed_cnt), 256'd0);
    check("rst_error", 256'(error), 256'd0);
    check("rst_sha_init", 256'(sha_init), 256'd0);
    check("rst_clear_input", sha_clear_input, 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_req_ready", 256'(req_ready), 256'd1);
    reset_n = 1'b1;
    tick();

    // First reseed from KEY_INIT=0, minimum latency with a zero-latency core
    do_reseed("rs1", SEED, 0, 0, lat);
    check("rs1_key_const", model_key, KEY1);
    check("rs1_latency", 256'(lat), 256'd4);

    // Second reseed chains through the previous key
    do_reseed("rs2", SEED, 3, 0, lat);

    // Core reports not-ready for 10 cycles after accept
    do_reseed("hold", 256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_0badf00d_cafebabe_13579bdf, 0, 10, lat);

    // Stale sha_hash_valid while idle must not update the key
    upd = 0;
    repeat (4) begin
      tick();
      if (key_update) upd++;
    end
    check("idle_stale_valid", 256'(upd), 256'd0);
    check("idle_key", key, model_key);

    // Timeout with a core that never answers
    core_dead = 1'b1;
    core_lat  = 0;
    req_valid = 1'b1; req_data = SEED;
    tick();
    req_valid = 1'b0; req_data = '0;
    for (int c = 1; c <= 14; c++) begin
      err_clear = (c >= 5 && c <= 7);
      tick();
    end
    err_clear = 1'b0;
    check("tmo_error_c14", 256'(error), 256'd0);
    check("tmo_busy_c14", 256'(busy), 256'd1);
    tick();
    check("tmo_error_c15", 256'(error), 256'd1);
    check("tmo_req_ready", 256'(req_ready), 256'd0);
    check("tmo_sha_init", 256'(sha_init), 256'd0);
    check("tmo_busy", 256'(busy), 256'd0);
    check("tmo_key", key, model_key);
    check("tmo_reseed_cnt", 256'(reseed_cnt), 256'(model_cnt));
    check("tmo_key_valid", 256'(key_valid), 256'd1);
    repeat (3) tick();
    check("tmo_sticky", 256'(error), 256'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_req_ready", 256'(req_ready), 256'd1);
    check("clr_error", 256'(error), 256'd0);
    core_dead = 1'b0;
    repeat (2) tick();

    // Reset asserted while waiting on the core
    core_lat  = 20;
    req_valid = 1'b1; req_data = SEED;
    tick();
    req_valid = 1'b0; req_data = '0;
    repeat (5) tick();
    check("wrst_in_wait", 256'(dut.state), 256'(ST_WAIT));
    reset_n = 1'b0;
    #1;
    check("wrst_key", key, 256'd0);
    check("wrst_reseed_cnt", 256'(reseed_cnt), 256'd0);
    check("wrst_key_valid", 256'(key_valid), 256'd0);
    check("wrst_busy", 256'(busy), 256'd0);
    check("wrst_clear_input", sha_clear_input, 256'd0);
    check("wrst_error", 256'(error), 256'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("wrst_req_ready", 256'(req_ready), 256'd1);
    upd = 0;
    repeat (5) begin
      tick();
      if (key_update) upd++;
    end
    check("wrst_no_update", 256'(upd), 256'd0);
    check("wrst_key_after", key, 256'd0);
    model_key = '0;
    model_cnt = '0;

    // Saturation of the reseed counter
    force dut.reseed_cnt = 32'hFFFFFFFF;
    tick();
    release dut.reseed_cnt;
    tick();
    model_cnt = 32'hFFFFFFFF;
    do_reseed("sat", SEED, 1, 0, lat);
    check("sat_cnt_final", 256'(reseed_cnt), 256'hFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fortuna_reseed_ctrl.md
FORTUNA_RESEED_CTRL -- requirements
Module: fortuna_reseed_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, max cycles from request accept to digest capture before error.
REQ-002 Parameter: KEY_INIT, 256'h0, generator key value after reset.
REQ-003 clk  in  1  single clock; all flops on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  seed material on req_data is offered.
REQ-006 req_ready  out  1  controller accepts seed this cycle.
REQ-007 req_data  in  256  seed material (pool digest).
REQ-008 sha_init  out  1  start pulse to the sha256d core.
REQ-009 sha_clear_input  out  256  block presented to the sha256d core.
REQ-010 sha_ready  in  1  sha256d core idle.
REQ-011 sha_hash  in  256  sha256d digest.
REQ-012 sha_hash_valid  in  1  sha_hash is valid.
REQ-013 key  out  256  current generator key.
REQ-014 key_valid  out  1  at least one reseed has completed.
REQ-015 key_update  out  1  one-cycle pulse when key changes.
REQ-016 reseed_cnt  out  32  Fortuna reseed counter C.
REQ-017 busy  out  1  reseed in progress.
REQ-018 error  out  1  sticky timeout flag.
REQ-019 err_clear  in  1  clears error state.

Function
REQ-020 The FSM SHALL have states IDLE, PEND, ISSUE, SETTLE, WAIT, ERROR.
REQ-021 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in PEND, ISSUE, SETTLE, WAIT.
REQ-022 On req_valid && req_ready, the block register SHALL latch key XOR req_data and the FSM SHALL go IDLE->PEND.
REQ-023 PEND->ISSUE when sha_ready=1; otherwise remain in PEND.
REQ-024 In ISSUE, sha_init SHALL be 1 for exactly one cycle; the FSM then goes to SETTLE.
REQ-025 SETTLE lasts exactly one cycle; sha_ready and sha_hash_valid are ignored in it; the FSM then goes to WAIT.
REQ-026 sha_clear_input SHALL equal the latched block and SHALL stay stable from PEND through WAIT.
REQ-027 In WAIT, when sha_ready=1 and sha_hash_valid=1, the controller SHALL load key<=sha_hash and go to IDLE.
REQ-028 On that same capture edge, key_update SHALL pulse for one cycle, key_valid SHALL be set, and reseed_cnt SHALL increment.
REQ-029 reseed_cnt SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-030 Minimum accept-to-key_update latency SHALL be 4 cycles plus the core latency.
REQ-031 A timeout counter SHALL clear on accept and count every cycle in PEND, ISSUE, SETTLE and WAIT.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES-1 without a capture, the FSM SHALL enter ERROR.
REQ-033 On a timeout, key, key_valid and reseed_cnt SHALL remain unchanged and error SHALL be set.
REQ-034 If a capture and a timeout occur in the same cycle, the capture SHALL win.
REQ-035 In ERROR, error=1, sha_init=0 and req_ready=0.
REQ-036 err_clear in ERROR SHALL go to IDLE and clear error on the next edge; err_clear in any other state SHALL be ignored.
REQ-037 sha_hash_valid without sha_ready, or outside WAIT, SHALL be ignored.

Reset
REQ-038 While reset_n=0, outputs SHALL be: state IDLE, key=KEY_INIT, key_valid=0, key_update=0, reseed_cnt=0, error=0, sha_init=0, sha_clear_input=0, busy=0.
REQ-039 Reset asserted mid-reseed SHALL abort the reseed with no key update, and req_ready=1 on the first edge after release.

Structure
REQ-040 A shared package fortuna_pkg SHALL hold the FSM state enum, KEY_W=256, CNT_W=32 and the TIMEOUT_CYCLES default.
REQ-041 No sub-module is needed; the integrator instantiates sha256d beside this block and wires the sha_* ports directly.

Verification
REQ-042 After reset with KEY_INIT=0, seed e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 -> sha_clear_input equals the seed, key=5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, reseed_cnt=1, key_valid=1.
REQ-043 Second reseed with the same seed -> sha_clear_input = previous key XOR seed, key matches the sha256d model, reseed_cnt=2.
REQ-044 sha_ready held 0 for 10 cycles after accept -> FSM stays in PEND, sha_init=0, then a single init pulse once sha_ready=1.
REQ-045 Stubbed core that never responds, TIMEOUT_CYCLES=16 -> error=1 at cycle 15 after accept, key unchanged; err_clear -> req_ready=1 next cycle.
REQ-046 reset_n dropped during WAIT -> all outputs at reset values, key=KEY_INIT, reseed_cnt=0.
REQ-047 reseed_cnt preloaded to FFFFFFFF via force, one reseed -> reseed_cnt stays FFFFFFFF.
